bus_slave_ctrl: RTL

BUS_SLAVE_CTRL -- requirements
Module: bus_slave_ctrl

---
 rtl/bus_slave_ctrl_pkg.sv | 24 ++
 rtl/bus_slave_ctrl_if.sv | 17 +
 rtl/bus_slave_mem.sv | 29 ++
 rtl/bus_slave_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/bus_slave_ctrl_pkg.sv
// Shared bus header: widths, direction encodings and strobe levels common to the
// arbiter, muxes, decoder and slaves, plus the latched-request type.
package bus_slave_ctrl_pkg;

    localparam int ADDR_WIDTH = 30;
    localparam int DATA_WIDTH = 32;
    localparam int CNT_W      = 4;

    localparam logic BUS_READ   = 1'b1;
    localparam logic BUS_WRITE  = 1'b0;
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    typedef struct packed {
        logic                  rw;
        logic [DATA_WIDTH-1:0] wdata;
    } bus_req_t;

    // Counter preload on WAIT entry; zero-wait builds never enter WAIT.
    function automatic logic [CNT_W-1:0] wait_load(input int wc);
        return (wc > 0) ? CNT_W'(wc - 1) : '0;
    endfunction

endpackage

// File: rtl/bus_slave_ctrl_if.sv
// Slave-side bus bundle: request from the master/decoder, response to the slave mux.
interface bus_slave_ctrl_if;
    import bus_slave_ctrl_pkg::*;

    logic                  cs;
    logic                  as;
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ready;
    logic                  busy;

    modport master (output cs, as, rw, addr, wr_data, input rd_data, ready, busy);
    modport slave  (input cs, as, rw, addr, wr_data, output rd_data, ready, busy);

endinterface

// File: rtl/bus_slave_mem.sv
// Local word storage: synchronous write, combinational read, whole-array clear.
module bus_slave_mem
    import bus_slave_ctrl_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic                  clk,
    input  logic                  i_clr,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_mem <= '{default: '0};
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/bus_slave_ctrl.sv
// Wait-state bus slave: accepts a request in IDLE, inserts WAIT_CYCLES wait states,
// then answers with a one-cycle registered ready strobe from local storage.
module bus_slave_ctrl
    import bus_slave_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int MEM_AW      = 6
) (
    input logic             clk,
    input logic             reset,
    bus_slave_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_wait_cnt, w_wait_cnt_nxt;
    logic [MEM_AW-1:0]     r_addr;
    bus_req_t              r_req;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  w_req;
    logic                  w_latch;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    logic                  w_addr_unused;

    // Upper address bits are deliberately dropped so storage aliases across the window.
    assign w_addr_unused = ^bus.addr[ADDR_WIDTH-1:MEM_AW];

    assign w_req = (bus.cs == 1'b1) && (bus.as == STROBE_ON);

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_latch        = 1'b0;
        w_mem_we       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_latch = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        w_state_nxt    = ST_WAIT;
                        w_wait_cnt_nxt = WAIT_LOAD;
                    end else begin
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                // Abort wins over the counter: a dropped request never completes.
                if (!w_req) begin
                    w_state_nxt    = ST_IDLE;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                w_mem_we    = (r_req.rw == BUS_WRITE);
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_req      <= '{rw: BUS_READ, wdata: '0};
            r_ready    <= STROBE_OFF;
            r_rd_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_latch) begin
                r_addr <= bus.addr[MEM_AW-1:0];
                r_req  <= '{rw: bus.rw, wdata: bus.wr_data};
            end
            // Response is registered, so ready/rd_data appear the cycle after RESP.
            if (r_state == ST_RESP) begin
                r_ready   <= STROBE_ON;
                r_rd_data <= (r_req.rw == BUS_READ) ? w_mem_rdata : '0;
            end else begin
                r_ready   <= STROBE_OFF;
                r_rd_data <= '0;
            end
        end
    end

    bus_slave_mem #(
        .AW (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .i_clr   (reset),
        .i_we    (w_mem_we),
        .i_addr  (r_addr),
        .i_wdata (r_req.wdata),
        .o_rdata (w_mem_rdata)
    );

    assign bus.ready   = r_ready;
    assign bus.rd_data = r_rd_data;
    assign bus.busy    = (r_state == ST_WAIT) || (r_state == ST_RESP);

endmodule
